pipelined_datapath: RTL and testbench

Parametrised successor to the CR16 single-cycle datapath: a register file plus ALU with a two-stage pipeline (execute, write-back), a valid/ready issue handshake, index-encoded destination selection, carry-chained addition and hazard handling. It sits between the CR16 controller/decoder and the memory interface and replaces the single-cycle datapath in deeper-clocked builds.

---
 rtl/cr16_pkg.sv | 28 ++
 rtl/cr16_alu.sv | 79 +++++++
 rtl/pipelined_datapath.sv | 103 ++++++++++
 tb/tb_pipelined_datapath.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared opcode, flag-index and reserved-opcode definitions for the CR16 pipelined datapath.
package cr16_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADDU = 4'd1,
      OP_ADDC = 4'd2,
      OP_SUB  = 4'd4,
      OP_CMP  = 4'd5,
      OP_AND  = 4'd6,
      OP_OR   = 4'd7,
      OP_XOR  = 4'd8,
      OP_NOT  = 4'd9,
      OP_LSH  = 4'd10,
      OP_ASHU = 4'd11,
      OP_MOV  = 4'd12
   } opcode_e;

   localparam logic [3:0] OP_RSVD = 4'd3;

   // bit positions inside the {C, L, F, Z, N} status vector
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/cr16_alu.sv
// Combinational CR16 ALU: result, {C,L,F,Z,N} flags, flag-update enable and write-back permission.
module cr16_alu
   import cr16_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [3:0]            opcode,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic [DATA_WIDTH-1:0] result,
   output logic [4:0]            flags,
   output logic                  flag_en,
   output logic                  wb_ok
);

   localparam int MSB = DATA_WIDTH - 1;

   logic                  cin_eff;
   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] amt;
   logic                  big;
   logic [DATA_WIDTH-1:0] shl;
   logic [DATA_WIDTH-1:0] shr_l;
   logic [DATA_WIDTH-1:0] shr_a;

   assign cin_eff = (opcode == OP_ADDC) & cin;
   assign sum     = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin_eff};
   // top bit of the widened difference is the borrow
   assign diff    = {1'b0, a} - {1'b0, b};

   // B is a signed shift count; magnitudes of DATA_WIDTH or more saturate
   assign amt   = b[MSB] ? (~b + 1'b1) : b;
   assign big   = amt >= DATA_WIDTH'(DATA_WIDTH);
   assign shl   = big ? '0 : (a << amt);
   assign shr_l = big ? '0 : (a >> amt);
   assign shr_a = big ? {DATA_WIDTH{a[MSB]}} : DATA_WIDTH'($signed(a) >>> amt);

   always_comb begin
      result  = '0;
      flags   = '0;
      flag_en = 1'b0;
      wb_ok   = 1'b1;
      case (opcode)
         OP_ADD, OP_ADDU, OP_ADDC: begin
            result         = sum[MSB:0];
            flag_en        = 1'b1;
            flags[FLAG_C]  = sum[DATA_WIDTH];
            flags[FLAG_F]  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            flags[FLAG_Z]  = (sum[MSB:0] == '0);
            flags[FLAG_N]  = sum[MSB];
         end
         OP_SUB, OP_CMP: begin
            result         = diff[MSB:0];
            flag_en        = 1'b1;
            flags[FLAG_C]  = diff[DATA_WIDTH];
            flags[FLAG_F]  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            flags[FLAG_Z]  = (diff[MSB:0] == '0);
            if (opcode == OP_CMP) begin
               flags[FLAG_N] = $signed(a) < $signed(b);
               flags[FLAG_L] = a < b;
               wb_ok         = 1'b0;
            end else begin
               flags[FLAG_N] = diff[MSB];
            end
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_LSH:  result = b[MSB] ? shr_l : shl;
         OP_ASHU: result = b[MSB] ? shr_a : shl;
         OP_MOV:  result = b;
         default: wb_ok  = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipelined_datapath.sv
// CR16 register file + ALU with execute/write-back pipe and valid/ready issue.
// CR16_DATAPATH_FORWARD_EN: bypass the pipe result to operands instead of stalling on a pending write.
module pipelined_datapath
   import cr16_pkg::*;
#(
   parameter int  DATA_WIDTH = 16,
   parameter int  REG_COUNT  = 16,
   localparam int SEL_W      = $clog2(REG_COUNT)
) (
   input  logic                  I_CLK,
   input  logic                  I_NRESET,
   input  logic                  I_ENABLE,
   input  logic                  I_VALID,
   output logic                  O_READY,
   input  logic [3:0]            I_OPCODE,
   input  logic [SEL_W-1:0]      I_REG_A_SELECT,
   input  logic [SEL_W-1:0]      I_REG_B_SELECT,
   input  logic                  I_IMMEDIATE_SELECT,
   input  logic [DATA_WIDTH-1:0] I_IMMEDIATE,
   input  logic                  I_WRITE_BACK,
   input  logic [SEL_W-1:0]      I_REG_DEST_SELECT,
   output logic [DATA_WIDTH-1:0] O_RESULT_BUS,
   output logic                  O_RESULT_VALID,
   output logic [4:0]            O_STATUS_FLAGS
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [SEL_W-1:0]      dest;
      logic                  wb;
      logic                  valid;
   } pipe_t;

   pipe_t                                pipe;
   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] rf;
   logic [4:0]                           flags;

   logic                  pipe_wr;
   logic                  hit_a;
   logic                  hit_b;
   logic                  accept;
   logic [DATA_WIDTH-1:0] opnd_a;
   logic [DATA_WIDTH-1:0] opnd_b;
   logic [DATA_WIDTH-1:0] rd_b;
   logic [DATA_WIDTH-1:0] alu_result;
   logic [4:0]            alu_flags;
   logic                  alu_flag_en;
   logic                  alu_wb_ok;

   // only operands actually consumed can collide with the pending write
   assign pipe_wr = pipe.valid & pipe.wb;
   assign hit_a   = pipe_wr && (pipe.dest == I_REG_A_SELECT) && (I_OPCODE != OP_MOV);
   assign hit_b   = pipe_wr && (pipe.dest == I_REG_B_SELECT) && !I_IMMEDIATE_SELECT;

`ifdef CR16_DATAPATH_FORWARD_EN
   assign opnd_a  = hit_a ? pipe.result : rf[I_REG_A_SELECT];
   assign rd_b    = hit_b ? pipe.result : rf[I_REG_B_SELECT];
   assign O_READY = I_ENABLE;
`else
   assign opnd_a  = rf[I_REG_A_SELECT];
   assign rd_b    = rf[I_REG_B_SELECT];
   assign O_READY = I_ENABLE & ~(hit_a | hit_b);
`endif

   assign opnd_b = I_IMMEDIATE_SELECT ? I_IMMEDIATE : rd_b;
   assign accept = I_VALID & O_READY;

   cr16_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .opcode  (I_OPCODE),
      .a       (opnd_a),
      .b       (opnd_b),
      .cin     (flags[FLAG_C]),
      .result  (alu_result),
      .flags   (alu_flags),
      .flag_en (alu_flag_en),
      .wb_ok   (alu_wb_ok)
   );

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         rf    <= '0;
         pipe  <= '0;
         flags <= '0;
      end else if (I_ENABLE) begin
         if (pipe_wr)
            rf[pipe.dest] <= pipe.result;
         if (accept) begin
            pipe <= '{result: alu_result, dest: I_REG_DEST_SELECT,
                      wb: I_WRITE_BACK & alu_wb_ok, valid: 1'b1};
            if (alu_flag_en)
               flags <= alu_flags;
         end else begin
            // result bus holds; only the valid marker drops
            pipe.valid <= 1'b0;
         end
      end
   end

   assign O_RESULT_BUS   = pipe.result;
   assign O_RESULT_VALID = pipe.valid;
   assign O_STATUS_FLAGS = flags;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed self-checking bench for pipelined_datapath (16 x 16-bit build).
module tb_pipelined_datapath;
   import cr16_pkg::*;

   logic        I_CLK = 1'b0;
   logic        I_NRESET;
   logic        I_ENABLE;
   logic        I_VALID;
   logic        O_READY;
   logic [3:0]  I_OPCODE;
   logic [3:0]  I_REG_A_SELECT;
   logic [3:0]  I_REG_B_SELECT;
   logic        I_IMMEDIATE_SELECT;
   logic [15:0] I_IMMEDIATE;
   logic        I_WRITE_BACK;
   logic [3:0]  I_REG_DEST_SELECT;
   logic [15:0] O_RESULT_BUS;
   logic        O_RESULT_VALID;
   logic [4:0]  O_STATUS_FLAGS;

   int n_chk  = 0;
   int n_fail = 0;
   int stalls = 0;

   pipelined_datapath #(.DATA_WIDTH(16), .REG_COUNT(16)) dut (
      .I_CLK              (I_CLK),
      .I_NRESET           (I_NRESET),
      .I_ENABLE           (I_ENABLE),
      .I_VALID            (I_VALID),
      .O_READY            (O_READY),
      .I_OPCODE           (I_OPCODE),
      .I_REG_A_SELECT     (I_REG_A_SELECT),
      .I_REG_B_SELECT     (I_REG_B_SELECT),
      .I_IMMEDIATE_SELECT (I_IMMEDIATE_SELECT),
      .I_IMMEDIATE        (I_IMMEDIATE),
      .I_WRITE_BACK       (I_WRITE_BACK),
      .I_REG_DEST_SELECT  (I_REG_DEST_SELECT),
      .O_RESULT_BUS       (O_RESULT_BUS),
      .O_RESULT_VALID     (O_RESULT_VALID),
      .O_STATUS_FLAGS     (O_STATUS_FLAGS)
   );

   always #5 I_CLK = ~I_CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // called at posedge+1; returns at posedge+1 of the accepting edge
   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic isel, input logic [15:0] imm, input logic wb,
                        input logic [3:0] d);
      logic got;
      got                = 1'b0;
      I_OPCODE           = op;
      I_REG_A_SELECT     = a;
      I_REG_B_SELECT     = b;
      I_IMMEDIATE_SELECT = isel;
      I_IMMEDIATE        = imm;
      I_WRITE_BACK       = wb;
      I_REG_DEST_SELECT  = d;
      I_VALID            = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge I_CLK);
         if (O_READY) got = 1'b1;
         else stalls++;
         @(posedge I_CLK);
         #1;
      end
      I_VALID = 1'b0;
      if (!got) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic mov_imm(input logic [3:0] d, input logic [15:0] v);
      issue(OP_MOV, 4'd0, 4'd0, 1'b1, v, 1'b1, d);
   endtask

   task automatic rd(input logic [3:0] r);
      issue(OP_MOV, 4'd0, r, 1'b0, 16'd0, 1'b0, 4'd0);
   endtask

   logic [15:0] fib [16];
   int          exp_stalls;

   initial begin
      I_NRESET = 1'b0; I_ENABLE = 1'b1; I_VALID = 1'b0;
      I_OPCODE = '0; I_REG_A_SELECT = '0; I_REG_B_SELECT = '0;
      I_IMMEDIATE_SELECT = 1'b0; I_IMMEDIATE = '0; I_WRITE_BACK = 1'b0;
      I_REG_DEST_SELECT = '0;
      repeat (3) @(posedge I_CLK);
      #1;
      check("rst_result", 32'(O_RESULT_BUS), 32'd0);
      check("rst_valid", 32'(O_RESULT_VALID), 32'd0);
      check("rst_flags", 32'(O_STATUS_FLAGS), 32'd0);
      @(negedge I_CLK) I_NRESET = 1'b1;
      @(posedge I_CLK); #1;

      // Fibonacci chain R0..R15
      fib[0] = 16'd1; fib[1] = 16'd1;
      for (int n = 2; n < 16; n++) fib[n] = fib[n-1] + fib[n-2];
      mov_imm(4'd0, 16'd1);
      check("mov_r0", 32'(O_RESULT_BUS), 32'd1);
      check("mov_valid", 32'(O_RESULT_VALID), 32'd1);
      mov_imm(4'd1, 16'd1);
      stalls = 0;
      for (int n = 0; n < 14; n++) begin
         issue(OP_ADD, 4'(n), 4'(n + 1), 1'b0, 16'd0, 1'b1, 4'(n + 2));
         check($sformatf("fib_r%0d", n + 2), 32'(O_RESULT_BUS), 32'(fib[n+2]));
      end
`ifdef CR16_DATAPATH_FORWARD_EN
      exp_stalls = 0;
`else
      exp_stalls = 14;
`endif
      check("fib_stalls", 32'(stalls), 32'(exp_stalls));
      check("fib_last", 32'(O_RESULT_BUS), 32'd987);
      rd(4'd15);
      check("rd_r15", 32'(O_RESULT_BUS), 32'd987);

      // result valid drops on an idle advancing edge
      @(posedge I_CLK); #1;
      check("idle_valid", 32'(O_RESULT_VALID), 32'd0);
      check("idle_hold", 32'(O_RESULT_BUS), 32'd987);

      // SUB 0 - 1
      mov_imm(4'd0, 16'd0);
      mov_imm(4'd1, 16'd1);
      issue(OP_SUB, 4'd0, 4'd1, 1'b0, 16'd0, 1'b1, 4'd2);
      check("sub_res", 32'(O_RESULT_BUS), 32'hFFFF);
      check("sub_flags", 32'(O_STATUS_FLAGS), 32'h11);

      // CMP 4 vs 7 then logic ops leave flags alone
      mov_imm(4'd0, 16'd7);
      mov_imm(4'd1, 16'd4);
      issue(OP_CMP, 4'd1, 4'd0, 1'b0, 16'd0, 1'b1, 4'd5);
      check("cmp_flags", 32'(O_STATUS_FLAGS), 32'h19);
      issue(OP_AND, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 4'd0);
      check("and", 32'(O_RESULT_BUS), 32'h4);
      issue(OP_OR, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 4'd0);
      check("or", 32'(O_RESULT_BUS), 32'h7);
      issue(OP_XOR, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 4'd0);
      check("xor", 32'(O_RESULT_BUS), 32'h3);
      issue(OP_NOT, 4'd0, 4'd1, 1'b0, 16'd0, 1'b0, 4'd0);
      check("not", 32'(O_RESULT_BUS), 32'hFFF8);
      check("logic_flags", 32'(O_STATUS_FLAGS), 32'h19);
      rd(4'd5);
      check("cmp_no_wb", 32'(O_RESULT_BUS), 32'd8);
      issue(OP_RSVD, 4'd0, 4'd1, 1'b0, 16'd0, 1'b1, 4'd6);
      check("rsvd_res", 32'(O_RESULT_BUS), 32'd0);
      check("rsvd_flags", 32'(O_STATUS_FLAGS), 32'h19);
      rd(4'd6);
      check("rsvd_no_wb", 32'(O_RESULT_BUS), 32'd13);

      // carry chain
      mov_imm(4'd0, 16'hFFFF);
      issue(OP_ADDU, 4'd0, 4'd0, 1'b1, 16'd1, 1'b1, 4'd3);
      check("addu_res", 32'(O_RESULT_BUS), 32'd0);
      check("addu_flags", 32'(O_STATUS_FLAGS), 32'h12);
      issue(OP_ADDC, 4'd3, 4'd3, 1'b0, 16'd0, 1'b1, 4'd4);
      check("addc_res", 32'(O_RESULT_BUS), 32'd1);
      check("addc_flags", 32'(O_STATUS_FLAGS), 32'h00);

      // shifts
      mov_imm(4'd0, 16'd1);
      issue(OP_LSH, 4'd0, 4'd0, 1'b1, 16'd15, 1'b1, 4'd1);
      check("lsh_15", 32'(O_RESULT_BUS), 32'h8000);
      issue(OP_ASHU, 4'd1, 4'd0, 1'b1, 16'hFFF1, 1'b0, 4'd0);
      check("ashu_m15", 32'(O_RESULT_BUS), 32'hFFFF);
      issue(OP_LSH, 4'd1, 4'd0, 1'b1, 16'hFFF1, 1'b0, 4'd0);
      check("lsh_m15", 32'(O_RESULT_BUS), 32'h0001);
      issue(OP_ASHU, 4'd1, 4'd0, 1'b1, 16'hFFF0, 1'b0, 4'd0);
      check("ashu_m16", 32'(O_RESULT_BUS), 32'hFFFF);
      issue(OP_LSH, 4'd0, 4'd0, 1'b1, 16'd16, 1'b0, 4'd0);
      check("lsh_16", 32'(O_RESULT_BUS), 32'd0);
      issue(OP_ASHU, 4'd0, 4'd0, 1'b1, 16'd3, 1'b0, 4'd0);
      check("ashu_l3", 32'(O_RESULT_BUS), 32'd8);

      // same destination back-to-back: newer value wins
      mov_imm(4'd4, 16'h0011);
      mov_imm(4'd4, 16'h0022);
      rd(4'd4);
      check("waw_r4", 32'(O_RESULT_BUS), 32'h0022);

      // reset between accept and write-back
      mov_imm(4'd0, 16'hFFFF);
      issue(OP_ADDU, 4'd0, 4'd0, 1'b1, 16'd1, 1'b1, 4'd8);
      mov_imm(4'd7, 16'h1234);
      check("pre_rst", 32'(O_RESULT_BUS), 32'h1234);
      I_NRESET = 1'b0;
      #1;
      check("mid_rst_result", 32'(O_RESULT_BUS), 32'd0);
      check("mid_rst_valid", 32'(O_RESULT_VALID), 32'd0);
      check("mid_rst_flags", 32'(O_STATUS_FLAGS), 32'd0);
      @(negedge I_CLK) I_NRESET = 1'b1;
      @(posedge I_CLK); #1;
      rd(4'd7);
      check("rst_r7", 32'(O_RESULT_BUS), 32'd0);

      // freeze with enable low for three cycles
      mov_imm(4'd0, 16'd5);
      mov_imm(4'd1, 16'd3);
      issue(OP_ADD, 4'd0, 4'd1, 1'b0, 16'd0, 1'b1, 4'd2);
      check("frz_add", 32'(O_RESULT_BUS), 32'd8);
      I_ENABLE = 1'b0;
      I_VALID = 1'b1; I_OPCODE = OP_MOV; I_REG_B_SELECT = 4'd0;
      I_IMMEDIATE_SELECT = 1'b1; I_IMMEDIATE = 16'h5555; I_WRITE_BACK = 1'b1;
      I_REG_DEST_SELECT = 4'd2;
      repeat (3) begin
         @(negedge I_CLK);
         check("frz_ready", 32'(O_READY), 32'd0);
         @(posedge I_CLK); #1;
         check("frz_result", 32'(O_RESULT_BUS), 32'd8);
         check("frz_valid", 32'(O_RESULT_VALID), 32'd1);
      end
      I_VALID = 1'b0;
      I_ENABLE = 1'b1;
      rd(4'd2);
      check("frz_r2", 32'(O_RESULT_BUS), 32'd8);
      issue(OP_ADD, 4'd2, 4'd0, 1'b0, 16'd0, 1'b1, 4'd3);
      check("frz_resume", 32'(O_RESULT_BUS), 32'd13);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
      $fatal(1, "timeout");
   end

endmodule
